// File: rtl/roi_pkg.sv
// Shared types, default geometry and the ROI membership test for roi_sampler.
package roi_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} roi_state_t;
    typedef enum logic [1:0] {CH_R = 2'd0, CH_G = 2'd1, CH_B = 2'd2} chan_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_ROI_X0     = 288;
    localparam int DEF_ROI_Y0     = 208;
    localparam int DEF_ROI_W      = 64;
    localparam int DEF_ROI_H      = 64;

    function automatic logic roi_hit(input int x, input int y, input int x0, input int y0,
                                     input int w, input int h);
        return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker. x/y/last describe the pixel presented this cycle;
// restart makes that pixel (0,0), advance consumes it.
module raster_counter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    parameter int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);
    localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

    logic [XW-1:0] x_q, x_n;
    logic [YW-1:0] y_q, y_n;

    assign x    = restart ? '0 : x_q;
    assign y    = restart ? '0 : y_q;
    assign last = (x == X_MAX) && (y == Y_MAX);

    always_comb begin
        x_n = x + XW'(1);
        y_n = y;
        if (x == X_MAX) begin
            x_n = '0;
            y_n = (y == Y_MAX) ? '0 : y + YW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (restart || advance) begin
            x_q <= x_n;
            y_q <= y_n;
        end
    end
endmodule

// File: rtl/roi_sampler.sv
// Raster ROI sampler feeding the average stage: one read-qualified channel sample per ROI pixel.
// Build option ROI_GRAY_EN replaces channel select with (R + 2G + B) >> 2.
module roi_sampler
    import roi_pkg::*;
#(
    parameter int data_width = DEF_DATA_WIDTH,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int ROI_X0     = DEF_ROI_X0,
    parameter int ROI_Y0     = DEF_ROI_Y0,
    parameter int ROI_W      = DEF_ROI_W,
    parameter int ROI_H      = DEF_ROI_H
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 sof,
    input  logic                                 pix_valid,
    input  logic [3*data_width-1:0]              pix_in,
    input  logic [1:0]                           chan_sel,
    output logic [data_width-1:0]                data_out,
    output logic                                 read,
    output logic                                 frame_done,
    output logic [$clog2(ROI_W*ROI_H+1)-1:0]     sample_cnt
);
    localparam int CW = $clog2(ROI_W*ROI_H+1);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    if (ROI_X0 + ROI_W > H_ACTIVE) begin : g_bad_roi_x
        $error("roi_sampler: ROI exceeds H_ACTIVE");
    end
    if (ROI_Y0 + ROI_H > V_ACTIVE) begin : g_bad_roi_y
        $error("roi_sampler: ROI exceeds V_ACTIVE");
    end

    roi_state_t state, state_n;
    logic          start, accept, hit, last;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [data_width-1:0] r, g, b, sample;

    // A sof pixel is taken in any state and always begins a fresh frame.
    assign start  = sof && pix_valid;
    assign accept = start || (state == ACTIVE && pix_valid);
    assign hit    = accept && roi_hit(int'(cur_x), int'(cur_y), ROI_X0, ROI_Y0, ROI_W, ROI_H);
    assign {r, g, b} = pix_in;

    raster_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .XW(XW), .YW(YW)) u_raster (
        .clk     (clk),
        .reset   (reset),
        .restart (start),
        .advance (accept),
        .x       (cur_x),
        .y       (cur_y),
        .last    (last)
    );

`ifdef ROI_GRAY_EN
    logic [data_width+1:0] gsum;
    logic                  unused_chan;
    assign unused_chan = ^chan_sel;
    assign gsum   = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    assign sample = gsum[data_width+1:2];
`else
    logic [1:0] chan_q, chan_cur;
    assign chan_cur = start ? chan_sel : chan_q;

    always_comb begin
        case (chan_cur)
            CH_R:    sample = r;
            CH_B:    sample = b;
            default: sample = g;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      chan_q <= CH_R;
        else if (start) chan_q <= chan_sel;
    end
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = last ? DONE : ACTIVE;
            ACTIVE:  if (accept) state_n = last ? DONE : ACTIVE;
            DONE:    state_n = start ? (last ? DONE : ACTIVE) : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            data_out   <= '0;
            read       <= 1'b0;
            frame_done <= 1'b0;
            sample_cnt <= '0;
        end else begin
            state      <= state_n;
            read       <= hit;
            frame_done <= accept && last;
            if (hit) data_out <= sample;
            if (start)    sample_cnt <= CW'(hit);
            else if (hit) sample_cnt <= sample_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_roi_sampler.sv
// Directed bench for roi_sampler on an 8x6 raster with ROI (2,1,3,2).
module tb_roi_sampler;
    localparam int H = 8, V = 6, X0 = 2, Y0 = 1, W = 3, RH = 2;
    localparam int CW = $clog2(W*RH+1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sof = 1'b0, pix_valid = 1'b0;
    logic [23:0]   pix_in = '0;
    logic [1:0]    chan_sel = '0;
    logic [7:0]    data_out;
    logic          read, frame_done;
    logic [CW-1:0] sample_cnt;

    roi_sampler #(.data_width(8), .H_ACTIVE(H), .V_ACTIVE(V), .ROI_X0(X0), .ROI_Y0(Y0),
                  .ROI_W(W), .ROI_H(RH)) dut (
        .clk(clk), .reset(reset), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .chan_sel(chan_sel), .data_out(data_out), .read(read), .frame_done(frame_done),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int gx = 0, gy = 0, mcnt = 0, mdata = 0, nfd = 0;
    bit mact = 0, use_const = 0;
    logic [1:0]  mch = '0;
    logic [23:0] const_pix = '0;
    int rq[$];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_val(input logic [23:0] p, input logic [1:0] ch);
`ifdef ROI_GRAY_EN
        return ((int'(p[23:16]) + 2*int'(p[15:8]) + int'(p[7:0])) >> 2) & 255;
`else
        case (ch)
            2'd0:    return int'(p[23:16]);
            2'd2:    return int'(p[7:0]);
            default: return int'(p[15:8]);
        endcase
`endif
    endfunction

    // One input cycle plus a full check of the registered outputs it produces.
    task automatic send(input bit s, input bit v, input logic [1:0] ch);
        logic [23:0] p;
        bit st, acc, hit, lst;
        if (s && v) begin gx = 0; gy = 0; end
        p = use_const ? const_pix : {8'(gx + 10*gy), 8'(100 + gx), 8'(150 + gy)};
        sof = s; pix_valid = v; pix_in = p; chan_sel = ch;
        st  = s && v;
        acc = v && (st || mact);
        if (st) begin mch = ch; mcnt = 0; end
        hit = acc && gx >= X0 && gx < X0 + W && gy >= Y0 && gy < Y0 + RH;
        lst = acc && gx == H-1 && gy == V-1;
        if (hit) begin mcnt++; mdata = model_val(p, mch); end
        @(posedge clk); #1;
        chk("read", int'(read), int'(hit));
        chk("data_out", int'(data_out), mdata);
        chk("sample_cnt", int'(sample_cnt), mcnt);
        chk("frame_done", int'(frame_done), int'(lst));
        if (read) rq.push_back(int'(data_out));
        if (frame_done) nfd++;
        if (st) mact = 1;
        if (lst) mact = 0;
        if (v) begin
            gx++;
            if (gx == H) begin gx = 0; gy = (gy == V-1) ? 0 : gy + 1; end
        end
    endtask

    task automatic frame(input bit stall, input logic [1:0] ch0);
        for (int i = 0; i < H*V; i++) begin
            send(i == 0, 1'b1, (i == 0) ? ch0 : 2'(i % 4));
            if (stall) send(1'b1, 1'b0, 2'((i + 1) % 4));
        end
        send(1'b0, 1'b0, 2'd0);
    endtask

    task automatic check_ramp(input string tag);
`ifdef ROI_GRAY_EN
        int exp_q[6] = '{91, 92, 93, 94, 95, 96};
`else
        int exp_q[6] = '{12, 13, 14, 22, 23, 24};
`endif
        chk({tag, "_n"}, rq.size(), 6);
        for (int i = 0; i < 6 && i < rq.size(); i++) chk({tag, "_val"}, rq[i], exp_q[i]);
        chk({tag, "_fd"}, nfd, 1);
    endtask

    task automatic const_frame(input string tag, input logic [23:0] p, input logic [1:0] ch, input int exp);
        use_const = 1; const_pix = p; rq.delete(); nfd = 0;
        frame(1'b0, ch);
        chk({tag, "_n"}, rq.size(), 6);
        for (int i = 0; i < rq.size(); i++) chk({tag, "_val"}, rq[i], exp);
        chk({tag, "_fd"}, nfd, 1);
        chk({tag, "_cnt"}, int'(sample_cnt), 6);
        use_const = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read", int'(read), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_cnt", int'(sample_cnt), 0);
        chk("rst_fd", int'(frame_done), 0);
        reset = 1'b0;

        // idle pixels without sof are ignored
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 2'd0);

        rq.delete(); nfd = 0;
        frame(1'b0, 2'd0);
        check_ramp("plain");
        chk("plain_hold_cnt", int'(sample_cnt), 6);

        rq.delete(); nfd = 0;
        frame(1'b1, 2'd0);
        check_ramp("stall");

        // abort at pixel 20: 5 samples from the aborted frame, then a full frame
        rq.delete(); nfd = 0;
        for (int i = 0; i < 20; i++) send(i == 0, 1'b1, 2'd0);
        chk("pre_abort_cnt", int'(sample_cnt), 5);
        frame(1'b0, 2'd0);
        chk("abort_n", rq.size(), 11);
        chk("abort_fd", nfd, 1);

        // reset mid-frame after 15 pixels
        for (int i = 0; i < 15; i++) send(i == 0, 1'b1, 2'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_read", int'(read), 0);
        chk("mid_rst_data", int'(data_out), 0);
        chk("mid_rst_cnt", int'(sample_cnt), 0);
        chk("mid_rst_fd", int'(frame_done), 0);
        mact = 0; mcnt = 0; mdata = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) send(1'b0, 1'b1, 2'd0);
        rq.delete(); nfd = 0;
        frame(1'b0, 2'd0);
        check_ramp("post_rst");

`ifdef ROI_GRAY_EN
        const_frame("c40_r", {8'd40, 8'd80, 8'd120}, 2'd0, 80);
        const_frame("c40_b", {8'd40, 8'd80, 8'd120}, 2'd2, 80);
`else
        const_frame("c40_r", {8'd40, 8'd80, 8'd120}, 2'd0, 40);
        const_frame("c40_b", {8'd40, 8'd80, 8'd120}, 2'd2, 120);
`endif
        const_frame("c255", {8'd255, 8'd255, 8'd255}, 2'd1, 255);
        const_frame("c100", {8'd100, 8'd50, 8'd0}, 2'd3, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
